audio_dac_sample_pacer: RTL and testbench



---
 rtl/audio_dac_sample_pacer_if.sv | 36 +++
 rtl/audio_dac_sample_pacer.sv | 146 ++++++++++++++
 tb/tb_audio_dac_sample_pacer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_dac_sample_pacer_if.sv
// Stream bundle between the DSP chain, the sample pacer and the ADAU1361 DAC inputs.
// The master side feeds samples in and watches the paced DAC strobes; the pacer is the slave.
interface audio_dac_sample_pacer_if #(
   parameter int unsigned DATA_WIDTH = 16
);
   logic signed [DATA_WIDTH-1:0] iS_left_data;
   logic signed [DATA_WIDTH-1:0] iS_right_data;
   logic                         i_valid;
   logic                         o_ready;
   logic signed [DATA_WIDTH-1:0] oS_left_dac_data;
   logic                         o_left_dac_valid;
   logic signed [DATA_WIDTH-1:0] oS_right_dac_data;
   logic                         o_right_dac_valid;

   modport master (
      output iS_left_data,
      output iS_right_data,
      output i_valid,
      input  o_ready,
      input  oS_left_dac_data,
      input  o_left_dac_valid,
      input  oS_right_dac_data,
      input  o_right_dac_valid
   );

   modport slave (
      input  iS_left_data,
      input  iS_right_data,
      input  i_valid,
      output o_ready,
      output oS_left_dac_data,
      output o_left_dac_valid,
      output oS_right_dac_data,
      output o_right_dac_valid
   );
endinterface

// File: rtl/audio_dac_sample_pacer.sv
// Buffers bursty stereo pairs and replays one pair per codec sample period as DAC strobes.
// Playback starts once PREFILL pairs are stored; an empty FIFO at a tick counts an underflow.
module audio_dac_sample_pacer #(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned FIFO_DEPTH    = 16,
   parameter int unsigned SAMPLE_PERIOD = 4096,
   parameter int unsigned PREFILL       = 8,
   localparam int unsigned AW = $clog2(FIFO_DEPTH),
   localparam int unsigned FW = AW + 1,
   localparam int unsigned CW = $clog2(SAMPLE_PERIOD)
) (
   input  logic                         i_clk,
   input  logic                         i_resetn,
   input  logic                         i_flush,
   audio_dac_sample_pacer_if.slave      bus,
   output logic [FW-1:0]                o_fill_level,
   output logic [7:0]                   o_underflow_count,
   output logic                         o_playing
);

   typedef enum logic [0:0] {StPrime, StRun} state_e;

   state_e                       state_q, state_d;
   logic [CW-1:0]                cnt_q;
   logic                         tick;
   logic [AW-1:0]                wr_ptr_q, rd_ptr_q;
   logic [FW-1:0]                fill_q;
   logic signed [DATA_WIDTH-1:0] left_mem_q  [FIFO_DEPTH];
   logic signed [DATA_WIDTH-1:0] right_mem_q [FIFO_DEPTH];
   logic signed [DATA_WIDTH-1:0] left_out_q, right_out_q;
   logic                         dac_valid_q;
   logic [7:0]                   uf_cnt_q;
   logic                         full, push, pop, underflow;

   assign tick        = (cnt_q == CW'(SAMPLE_PERIOD - 1));
   assign full        = (fill_q == FW'(FIFO_DEPTH));
   assign bus.o_ready = !full && !i_flush;
   assign push        = bus.i_valid && bus.o_ready;

   // Sample-period timebase; deliberately untouched by flush so the codec cadence never slips.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         state_q <= StPrime;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (i_flush) begin
         state_d = StPrime;
      end else begin
         unique case (state_q)
            StPrime: if (fill_q >= FW'(PREFILL)) state_d = StRun;
            StRun:   if (tick && (fill_q == '0)) state_d = StPrime;
            default: state_d = StPrime;
         endcase
      end
   end

   // A tick that coincides with flush still strobes, but carries 0/0 and is not an underflow.
   always_comb begin
      pop       = 1'b0;
      underflow = 1'b0;
      o_playing = 1'b0;
      unique case (state_q)
         StRun: begin
            o_playing = 1'b1;
            if (tick && !i_flush) begin
               pop       = (fill_q != '0);
               underflow = (fill_q == '0);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else if (i_flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         fill_q <= fill_q + FW'(push) - FW'(pop);
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            left_mem_q[i]  <= '0;
            right_mem_q[i] <= '0;
         end
      end else if (push) begin
         left_mem_q[wr_ptr_q]  <= bus.iS_left_data;
         right_mem_q[wr_ptr_q] <= bus.iS_right_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         dac_valid_q <= 1'b0;
         left_out_q  <= '0;
         right_out_q <= '0;
      end else begin
         dac_valid_q <= tick;
         if (tick) begin
            left_out_q  <= pop ? left_mem_q[rd_ptr_q]  : '0;
            right_out_q <= pop ? right_mem_q[rd_ptr_q] : '0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         uf_cnt_q <= '0;
      end else if (underflow && (uf_cnt_q != 8'hFF)) begin
         uf_cnt_q <= uf_cnt_q + 8'd1;
      end
   end

   assign bus.oS_left_dac_data  = left_out_q;
   assign bus.oS_right_dac_data = right_out_q;
   assign bus.o_left_dac_valid  = dac_valid_q;
   assign bus.o_right_dac_valid = dac_valid_q;
   assign o_fill_level          = fill_q;
   assign o_underflow_count     = uf_cnt_q;

endmodule

// File: tb/tb_audio_dac_sample_pacer.sv
// Directed bench for audio_dac_sample_pacer with SAMPLE_PERIOD=16, FIFO_DEPTH=8, PREFILL=4.
// Cycle numbers count rising edges since the last reset release.
module tb_audio_dac_sample_pacer;
   localparam int unsigned DW = 16;
   localparam int unsigned FD = 8;
   localparam int unsigned SP = 16;
   localparam int unsigned PF = 4;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       flush = 1'b0;
   logic [3:0] fill;
   logic [7:0] ucount;
   logic       playing;

   audio_dac_sample_pacer_if #(.DATA_WIDTH(DW)) bus ();

   audio_dac_sample_pacer #(
      .DATA_WIDTH   (DW),
      .FIFO_DEPTH   (FD),
      .SAMPLE_PERIOD(SP),
      .PREFILL      (PF)
   ) dut (
      .i_clk            (clk),
      .i_resetn         (resetn),
      .i_flush          (flush),
      .bus              (bus.slave),
      .o_fill_level     (fill),
      .o_underflow_count(ucount),
      .o_playing        (playing)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int ramp     = 0;
   bit stream_en = 1'b0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic drive(input int l, input bit v);
      bus.i_valid       = v;
      bus.iS_left_data  = 16'(l);
      bus.iS_right_data = 16'(-l);
   endtask

   // In stream mode the ramp advances only on an accepted handshake.
   task automatic step();
      bit acc;
      acc = stream_en && bus.o_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
         ramp++;
         drive(ramp, 1'b1);
      end
   endtask

   task automatic wait_strobe(input string tag);
      for (int i = 0; i < 40; i++) begin
         step();
         if (bus.o_left_dac_valid) break;
      end
      check_eq(tag, int'({bus.o_left_dac_valid, bus.o_right_dac_valid}), 3);
   endtask

   task automatic check_out(input string tag, input int l, input int r);
      check_eq({tag, "_left"}, int'(bus.oS_left_dac_data), l);
      check_eq({tag, "_right"}, int'(bus.oS_right_dac_data), r);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      resetn = 1'b1;
      cyc    = 0;
   endtask

   task automatic check_first_strobe(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < SP - 1; i++) begin
         step();
         seen |= bus.o_left_dac_valid | bus.o_right_dac_valid;
      end
      check_eq({tag, "_no_early_strobe"}, int'(seen), 0);
      step();
      check_eq({tag, "_strobe_at_period"}, int'({bus.o_left_dac_valid, bus.o_right_dac_valid}), 3);
      check_out({tag, "_data"}, 0, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      drive(0, 1'b0);
      repeat (2) @(posedge clk);
      release_reset();

      // Reset state and idle strobes carrying silence
      check_eq("rst_fill", int'(fill), 0);
      check_eq("rst_ucount", int'(ucount), 0);
      check_eq("rst_playing", int'(playing), 0);
      check_eq("rst_valid", int'(bus.o_left_dac_valid), 0);
      check_eq("rst_ready", int'(bus.o_ready), 1);
      check_out("rst", 0, 0);
      check_first_strobe("idle");
      check_eq("idle_playing", int'(playing), 0);
      step();
      check_eq("strobe_one_cycle", int'(bus.o_left_dac_valid), 0);
      wait_strobe("idle_strobe2");
      check_eq("idle_strobe2_cycle", cyc, 32);

      // Prefill four pairs, play them, then underflow
      for (int i = 0; i < 4; i++) begin
         drive((i + 1) * 100, 1'b1);
         step();
      end
      drive(0, 1'b0);
      check_eq("prefill_fill", int'(fill), 4);
      check_eq("prefill_not_yet_playing", int'(playing), 0);
      step();
      check_eq("prefill_playing", int'(playing), 1);
      for (int i = 0; i < 4; i++) begin
         wait_strobe("play_strobe");
         check_eq("play_cycle", cyc, 48 + 16 * i);
         check_out("play", (i + 1) * 100, -(i + 1) * 100);
         check_eq("play_fill", int'(fill), 3 - i);
      end
      wait_strobe("uf_strobe");
      check_out("uf", 0, 0);
      check_eq("uf_count", int'(ucount), 1);
      check_eq("uf_playing", int'(playing), 0);

      // Continuous ramp into a full FIFO
      ramp = 1000;
      stream_en = 1'b1;
      drive(ramp, 1'b1);
      for (int k = 0; k < 3; k++) begin
         wait_strobe("full_strobe");
         check_out("full", 1000 + k, -(1000 + k));
         check_eq("full_pop_fill", int'(fill), 7);
         check_eq("full_pop_ready", int'(bus.o_ready), 1);
         step();
         check_eq("full_refill", int'(fill), 8);
         check_eq("full_ready_low", int'(bus.o_ready), 0);
      end
      stream_en = 1'b0;
      drive(0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         wait_strobe("drain_strobe");
         check_out("drain", 1003 + k, -(1003 + k));
         check_eq("drain_fill", int'(fill), 7 - k);
      end

      // Push coinciding with a pop at fill 3
      while (cyc < 255) step();
      drive(2000, 1'b1);
      step();
      check_eq("pp_strobe", int'(bus.o_left_dac_valid), 1);
      check_out("pp", 1008, -1008);
      check_eq("pp_fill", int'(fill), 3);
      for (int i = 1; i <= 3; i++) begin
         drive(2000 + i, 1'b1);
         step();
      end
      drive(0, 1'b0);
      check_eq("preflush_fill", int'(fill), 6);
      check_eq("preflush_playing", int'(playing), 1);

      // Flush while running
      flush = 1'b1;
      drive(5000, 1'b1);
      #1;
      check_eq("flush_ready", int'(bus.o_ready), 0);
      step();
      check_eq("flush_fill", int'(fill), 0);
      check_eq("flush_playing", int'(playing), 0);
      flush = 1'b0;
      drive(0, 1'b0);
      #1;
      check_eq("postflush_ready", int'(bus.o_ready), 1);
      wait_strobe("postflush_strobe");
      check_eq("postflush_cycle", cyc, 272);
      check_out("postflush", 0, 0);
      check_eq("postflush_ucount", int'(ucount), 1);

      // Asynchronous reset in the middle of a burst
      for (int i = 0; i < 4; i++) begin
         drive(3000 + i, 1'b1);
         step();
      end
      drive(0, 1'b0);
      step();
      wait_strobe("burst_strobe");
      check_out("burst", 3000, -3000);
      drive(3004, 1'b1);
      step();
      drive(3005, 1'b1);
      step();
      check_eq("burst_fill", int'(fill), 5);
      #3;
      resetn = 1'b0;
      #1;
      check_out("async_rst", 0, 0);
      check_eq("async_rst_fill", int'(fill), 0);
      check_eq("async_rst_ucount", int'(ucount), 0);
      check_eq("async_rst_playing", int'(playing), 0);
      check_eq("async_rst_valid", int'(bus.o_left_dac_valid), 0);
      drive(0, 1'b0);
      release_reset();
      check_first_strobe("after_rst");

      // Underflow counter saturation
      for (int i = 0; i < 300; i++) begin
         for (int j = 0; j < 4; j++) begin
            drive(j + 1, 1'b1);
            step();
         end
         drive(0, 1'b0);
         repeat (5) wait_strobe("sat_strobe");
         if (i == 0) check_eq("sat_first", int'(ucount), 1);
         if (i == 254) check_eq("sat_255", int'(ucount), 255);
      end
      check_eq("sat_final", int'(ucount), 255);
      check_eq("sat_playing", int'(playing), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
